// File: rtl/axi4_rd_mem_slave.sv
// AXI4 read-channel slave over an internal word memory: queued AR requests,
// FIXED/INCR/WRAP address generation, per-beat SLVERR/DECERR and a backdoor write port.
module axi4_rd_mem_slave #(
    parameter int N           = 4,
    parameter int I           = 4,
    parameter int A           = 32,
    parameter int DEPTH       = 1024,
    parameter int OUTSTANDING = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [I-1:0]               ARID,
    input  logic [A-1:0]               ARADDR,
    input  logic [7:0]                 ARLEN,
    input  logic [2:0]                 ARSIZE,
    input  logic [1:0]                 ARBURST,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [I-1:0]               RID,
    output logic [8*N-1:0]             RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RLAST,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic                       mem_we,
    input  logic [$clog2(DEPTH)-1:0]   mem_waddr,
    input  logic [8*N-1:0]             mem_wdata
);
    localparam int LGN = $clog2(N);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW  = $clog2(OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BEAT} state_t;

    typedef struct packed {
        logic [I-1:0] id;
        logic [A-1:0] addr;
        logic [7:0]   len;
        logic [2:0]   size;
        logic [1:0]   burst;
    } req_t;

    function automatic logic [A-1:0] next_addr(input logic [A-1:0] addr, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst);
        logic [A-1:0] step;
        logic [A-1:0] bnd;
        logic [A-1:0] base;
        step = A'(1) << size;
        bnd  = A'({1'b0, len} + 9'd1) * step;
        base = addr & ~(bnd - A'(1));
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = base + ((addr + step) & (bnd - A'(1)));
            default: next_addr = (addr & ~(step - A'(1))) + step;
        endcase
    endfunction

    function automatic logic burst_slverr(input logic [2:0] size, input logic [7:0] len,
                                          input logic [1:0] burst);
        burst_slverr = (int'(size) > LGN) || (burst == 2'b11) ||
                       ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    req_t           r_fifo [OUTSTANDING];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [8*N-1:0] r_mem [DEPTH];

    state_t         r_state;
    logic [I-1:0]   r_id;
    logic [A-1:0]   r_addr;
    logic [7:0]     r_len;
    logic [7:0]     r_beat;
    logic [2:0]     r_size;
    logic [1:0]     r_burst;

    logic           w_push;
    logic           w_pop;
    logic           w_hs;
    logic           w_load;
    logic [CW-1:0]  w_count_nxt;
    logic [A-1:0]   w_beat_addr;
    logic [A-1:0]   w_word;
    logic           w_decerr;
    logic           w_slverr;
    logic [7:0]     w_beat_nxt;
    logic [8*N-1:0] w_rdword;
    req_t           w_head;

    assign w_head      = r_fifo[r_rptr];
    assign w_push      = ARVALID && ARREADY;
    assign w_hs        = RVALID && RREADY;
    // The next request is popped on the last handshake so bursts are separated by a single bubble.
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || (w_hs && RLAST));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_load      = (r_state == S_LOAD) || (w_hs && !RLAST);
    assign w_beat_addr = (r_state == S_LOAD) ? r_addr : next_addr(r_addr, r_size, r_len, r_burst);
    assign w_beat_nxt  = (r_state == S_LOAD) ? 8'd0 : r_beat + 8'd1;
    assign w_word      = w_beat_addr >> LGN;
    assign w_decerr    = (w_word >= A'(DEPTH));
    assign w_slverr    = burst_slverr(r_size, r_len, r_burst);
    assign w_rdword    = r_mem[w_word[AW-1:0]];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= 2'b00;
            RID     <= '0;
            RDATA   <= '0;
        end else begin
            r_count <= w_count_nxt;
            ARREADY <= (w_count_nxt < CW'(OUTSTANDING));
            if (w_push) r_wptr <= (r_wptr == PW'(OUTSTANDING - 1)) ? '0 : r_wptr + PW'(1);
            if (w_pop)  r_rptr <= (r_rptr == PW'(OUTSTANDING - 1)) ? '0 : r_rptr + PW'(1);

            case (r_state)
                S_IDLE: if (w_pop) r_state <= S_LOAD;
                S_LOAD: begin
                    r_state <= S_BEAT;
                    RVALID  <= 1'b1;
                end
                default: begin
                    if (w_hs && RLAST) begin
                        RVALID  <= 1'b0;
                        RLAST   <= 1'b0;
                        r_state <= w_pop ? S_LOAD : S_IDLE;
                    end
                end
            endcase

            if (w_load) begin
                RID   <= r_id;
                RLAST <= (w_beat_nxt == r_len);
                RDATA <= (w_slverr || w_decerr) ? '0 : w_rdword;
                RRESP <= w_slverr ? 2'b10 : (w_decerr ? 2'b11 : 2'b00);
            end
        end
    end

    // Burst context and memory carry no reset; memory must survive a mid-burst reset.
    always_ff @(posedge ACLK) begin
        if (w_push) r_fifo[r_wptr] <= '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
        if (w_pop) begin
            r_id    <= w_head.id;
            r_addr  <= w_head.addr;
            r_len   <= w_head.len;
            r_size  <= w_head.size;
            r_burst <= w_head.burst;
        end else if (w_load) begin
            r_addr  <= w_beat_addr;
        end
        if (w_load) r_beat <= w_beat_nxt;
        if (mem_we) r_mem[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_axi4_rd_mem_slave.sv
// Directed bench for axi4_rd_mem_slave: bursts, backpressure, outstanding limit, errors, reset, backdoor.
module tb_axi4_rd_mem_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    axi4_rd_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Holds ARVALID until accepted; returns on the falling edge after the handshake edge.
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        hs = 1'b0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        for (int t = 0; t < 200; t++) begin
            hs = ARREADY;
            @(negedge ACLK);
            if (hs) break;
        end
        ARVALID = 1'b0;
        if (hs) n_acc++;
        else check("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic recv_beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                             input logic last, input logic [3:0] id);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (RVALID) begin
                seen = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        if (!seen) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_data"}, 64'(RDATA), 64'(d));
            check({tag, "_resp"}, 64'(RRESP), 64'(resp));
            check({tag, "_last"}, 64'(RLAST), 64'(last));
            check({tag, "_id"},   64'(RID),   64'(id));
            @(negedge ACLK);
        end
    endtask

    task automatic recv_incr4(input string tag, input logic [31:0] first, input logic [3:0] id);
        for (int b = 0; b < 4; b++) recv_beat(tag, first + 32'(b), 2'b00, (b == 3), id);
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_rlast",   64'(RLAST),   64'd0);
        check("rst_rresp",   64'(RRESP),   64'd0);
        check("rst_rid",     64'(RID),     64'd0);
        check("rst_rdata",   64'(RDATA),   64'd0);
        ARESETn = 1'b1;

        for (int k = 0; k < 1024; k++) begin
            mem_we = 1'b1; mem_waddr = 10'(k); mem_wdata = 32'(k);
            @(negedge ACLK);
        end
        mem_we = 1'b0;

        // INCR with first-beat latency
        RREADY = 1'b1;
        send_ar(4'd3, 32'h10, 8'd3, 3'd2, 2'b01);
        check("lat_e0", 64'(RVALID), 64'd0);
        @(negedge ACLK);
        check("lat_e1", 64'(RVALID), 64'd0);
        @(negedge ACLK);
        check("lat_e2", 64'(RVALID), 64'd1);
        recv_incr4("incr", 32'd4, 4'd3);
        check("incr_idle", 64'(RVALID), 64'd0);

        send_ar(4'd5, 32'h18, 8'd3, 3'd2, 2'b10);
        recv_beat("wrap0", 32'd6, 2'b00, 1'b0, 4'd5);
        recv_beat("wrap1", 32'd7, 2'b00, 1'b0, 4'd5);
        recv_beat("wrap2", 32'd4, 2'b00, 1'b0, 4'd5);
        recv_beat("wrap3", 32'd5, 2'b00, 1'b1, 4'd5);

        send_ar(4'd6, 32'h8, 8'd2, 3'd2, 2'b00);
        recv_beat("fix0", 32'd2, 2'b00, 1'b0, 4'd6);
        recv_beat("fix1", 32'd2, 2'b00, 1'b0, 4'd6);
        recv_beat("fix2", 32'd2, 2'b00, 1'b1, 4'd6);

        // backpressure during beat 2
        send_ar(4'd1, 32'h40, 8'd3, 3'd2, 2'b01);
        recv_beat("hold0", 32'd16, 2'b00, 1'b0, 4'd1);
        RREADY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check("hold_vld",  64'(RVALID), 64'd1);
            check("hold_data", 64'(RDATA),  64'd17);
            check("hold_last", 64'(RLAST),  64'd0);
            check("hold_id",   64'(RID),    64'd1);
            check("hold_resp", 64'(RRESP),  64'd0);
        end
        RREADY = 1'b1;
        recv_beat("hold1", 32'd17, 2'b00, 1'b0, 4'd1);
        recv_beat("hold2", 32'd18, 2'b00, 1'b0, 4'd1);
        recv_beat("hold3", 32'd19, 2'b00, 1'b1, 4'd1);

        // outstanding limit: one in the engine plus four queued
        RREADY = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 5; k++) send_ar(4'(k), 32'h100 + 32'(16 * k), 8'd1, 3'd2, 2'b01);
        check("os_accepted", 64'(n_acc), 64'd5);
        ARID = 4'd5; ARADDR = 32'h150; ARLEN = 8'd1; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARVALID = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("os_full", 64'(ARREADY), 64'd0);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        recv_beat("os0a", 32'd64, 2'b00, 1'b0, 4'd0);
        recv_beat("os0b", 32'd65, 2'b00, 1'b1, 4'd0);
        check("os_reopen", 64'(ARREADY), 64'd1);
        check("os_bubble0", 64'(RVALID), 64'd0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("os_next0", 64'(RVALID), 64'd1);
        for (int k = 1; k < 6; k++) begin
            recv_beat("osa", 32'(64 + 4 * k), 2'b00, 1'b0, 4'(k));
            recv_beat("osb", 32'(65 + 4 * k), 2'b00, 1'b1, 4'(k));
            if (k < 5) begin
                check("os_bubble", 64'(RVALID), 64'd0);
                @(negedge ACLK);
                check("os_next", 64'(RVALID), 64'd1);
            end
        end

        // error responses
        send_ar(4'd7, 32'hFF8, 8'd3, 3'd2, 2'b01);
        recv_beat("dec0", 32'd1022, 2'b00, 1'b0, 4'd7);
        recv_beat("dec1", 32'd1023, 2'b00, 1'b0, 4'd7);
        recv_beat("dec2", 32'd0,    2'b11, 1'b0, 4'd7);
        recv_beat("dec3", 32'd0,    2'b11, 1'b1, 4'd7);
        send_ar(4'd8, 32'h0, 8'd1, 3'd2, 2'b11);
        recv_beat("rsv0", 32'd0, 2'b10, 1'b0, 4'd8);
        recv_beat("rsv1", 32'd0, 2'b10, 1'b1, 4'd8);
        send_ar(4'd9, 32'h0, 8'd2, 3'd2, 2'b10);
        recv_beat("wlen0", 32'd0, 2'b10, 1'b0, 4'd9);
        recv_beat("wlen1", 32'd0, 2'b10, 1'b0, 4'd9);
        recv_beat("wlen2", 32'd0, 2'b10, 1'b1, 4'd9);

        // reset in the middle of a burst
        send_ar(4'd2, 32'h10, 8'd3, 3'd2, 2'b01);
        recv_beat("mid0", 32'd4, 2'b00, 1'b0, 4'd2);
        RREADY = 1'b0;
        #1 ARESETn = 1'b0;
        #1;
        check("mid_rst_rvalid",  64'(RVALID),  64'd0);
        check("mid_rst_arready", 64'(ARREADY), 64'd0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        RREADY = 1'b1;
        send_ar(4'd4, 32'h10, 8'd3, 3'd2, 2'b01);
        recv_incr4("retain", 32'd4, 4'd4);

        // backdoor write then read
        mem_we = 1'b1; mem_waddr = 10'd9; mem_wdata = 32'hA5A5A5A5;
        @(negedge ACLK);
        mem_we = 1'b0;
        send_ar(4'd10, 32'h24, 8'd0, 3'd2, 2'b01);
        recv_beat("bdoor", 32'hA5A5A5A5, 2'b00, 1'b1, 4'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
